// File: rtl/if_id_buffer_pkg.sv
// rtl/if_id_buffer_pkg.sv - shared pipeline constants for the IF/ID boundary
package if_id_buffer_pkg;

    // Default datapath width for PC and instruction words.
    localparam int XLEN_DEFAULT = 32;

    // addi x0, x0, 0 -- presented to ID whenever no real instruction is available.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Word-aligned fetch addresses have their two low bits clear.
    function automatic logic pc_misaligned(input logic [1:0] pc_low);
        return pc_low != 2'b00;
    endfunction

endpackage

// File: rtl/if_id_buffer.sv
// rtl/if_id_buffer.sv - two-entry skid FIFO between fetch and decode
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid_i,
    input  logic [XLEN-1:0] pc_if_i,
    input  logic [XLEN-1:0] instr_if_i,
    output logic            if_ready_o,
    input  logic            flush_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [XLEN-1:0] pc_id_o,
    output logic [XLEN-1:0] instr_id_o,
    output logic            misalign_o,
    output logic [1:0]      count_o
);

    // Occupancy limit; the pointer and count widths below assume two entries.
    localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

    logic [XLEN-1:0] pc_mem    [2];
    logic [XLEN-1:0] instr_mem [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      count;
    logic            push;
    logic            pop;

    // Handshakes depend only on registered occupancy, never on id_ready_i.
    assign if_ready_o = (count != FULL_COUNT);
    assign id_valid_o = (count != 2'd0);
    assign count_o    = count;

    // A redirect suppresses both transfers in the cycle it is asserted.
    assign push = if_valid_i && if_ready_o && !flush_i;
    assign pop  = id_valid_o && id_ready_i && !flush_i;

    // Pointer and occupancy bookkeeping; flush and reset empty the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush_i) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until the count says otherwise.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= pc_if_i;
            instr_mem[wr_ptr] <= instr_if_i;
        end
    end

    // Head presentation; an empty buffer shows a NOP at address zero.
    always_comb begin
        pc_id_o    = '0;
        instr_id_o = XLEN'(NOP_INSTR);
        misalign_o = 1'b0;
        if (id_valid_o) begin
            pc_id_o    = pc_mem[rd_ptr];
            instr_id_o = instr_mem[rd_ptr];
            misalign_o = pc_misaligned(pc_mem[rd_ptr][1:0]);
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// tb/tb_if_id_buffer.sv - self-checking bench for if_id_buffer
module tb_if_id_buffer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        if_valid_i;
    logic [31:0] pc_if_i;
    logic [31:0] instr_if_i;
    logic        if_ready_o;
    logic        flush_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] pc_id_o;
    logic [31:0] instr_id_o;
    logic        misalign_o;
    logic [1:0]  count_o;

    int errors = 0;
    int checks = 0;

    if_id_buffer #(.XLEN(32), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_valid_i (if_valid_i),
        .pc_if_i    (pc_if_i),
        .instr_if_i (instr_if_i),
        .if_ready_o (if_ready_o),
        .flush_i    (flush_i),
        .id_valid_o (id_valid_o),
        .id_ready_i (id_ready_i),
        .pc_id_o    (pc_id_o),
        .instr_id_o (instr_id_o),
        .misalign_o (misalign_o),
        .count_o    (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rdy;
        logic        fl;
        logic [1:0]  cnt;
        logic        vld;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic        mis;
        logic        irdy;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    vec_t vecs[$];
    ent_t model_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                         input logic rdy, input logic fl);
        if_valid_i = iv;
        pc_if_i    = pc;
        instr_if_i = instr;
        id_ready_i = rdy;
        flush_i    = fl;
    endtask

    // One clock edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [1:0] cnt, input logic vld,
                             input logic [31:0] epc, input logic [31:0] einstr,
                             input logic mis, input logic irdy);
        chk({tag, ".count"},    32'(count_o),    32'(cnt));
        chk({tag, ".id_valid"}, 32'(id_valid_o), 32'(vld));
        chk({tag, ".pc"},       pc_id_o,         epc);
        chk({tag, ".instr"},    instr_id_o,      einstr);
        chk({tag, ".misalign"}, 32'(misalign_o), 32'(mis));
        chk({tag, ".if_ready"}, 32'(if_ready_o), 32'(irdy));
    endtask

    // Reference: queue of pairs; compare head/occupancy after the model's edge.
    task automatic model_edge(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                              input logic rdy, input logic fl);
        int sz;
        sz = model_q.size();
        if (fl) begin
            model_q.delete();
        end else begin
            if (sz != 0 && rdy) void'(model_q.pop_front());
            if (iv && sz != 2) model_q.push_back('{pc: pc, instr: instr});
        end
    endtask

    task automatic check_model(input string tag);
        if (model_q.size() == 0)
            check_all(tag, 2'd0, 1'b0, 32'h0, NOP, 1'b0, 1'b1);
        else
            check_all(tag, 2'(model_q.size()), 1'b1, model_q[0].pc, model_q[0].instr,
                      model_q[0].pc[1:0] != 2'b00, model_q.size() != 2);
    endtask

    function automatic vec_t mk(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                                input logic rdy, input logic fl, input logic [1:0] cnt,
                                input logic vld, input logic [31:0] epc,
                                input logic [31:0] einstr, input logic mis, input logic irdy);
        vec_t v;
        v.iv = iv; v.pc = pc; v.instr = instr; v.rdy = rdy; v.fl = fl;
        v.cnt = cnt; v.vld = vld; v.epc = epc; v.einstr = einstr; v.mis = mis; v.irdy = irdy;
        return v;
    endfunction

    initial begin
        logic [31:0] sp;
        logic        iv, rdy, fl;
        logic [31:0] rpc, rin;

        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 2'd0, 1'b0, 32'h0, NOP, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Single push, backpressure fill, overflow drop, drain.
        vecs.push_back(mk(1, 32'h00, 32'h0050_0093, 0, 0, 1, 1, 32'h00, 32'h0050_0093, 0, 1));
        vecs.push_back(mk(1, 32'h04, 32'h0010_0113, 0, 0, 2, 1, 32'h00, 32'h0050_0093, 0, 0));
        vecs.push_back(mk(1, 32'h08, 32'h0020_0193, 0, 0, 2, 1, 32'h00, 32'h0050_0093, 0, 0));
        vecs.push_back(mk(0, 32'h00, 32'h0,         1, 0, 1, 1, 32'h04, 32'h0010_0113, 0, 1));
        vecs.push_back(mk(0, 32'h00, 32'h0,         1, 0, 0, 0, 32'h00, NOP,            0, 1));
        // Streaming: one in, one out every cycle, pointers wrap repeatedly.
        for (int i = 0; i < 8; i++) begin
            sp = 32'(i * 4);
            vecs.push_back(mk(1, sp, 32'h1000_0000 | sp, 1, 0, 1, 1, sp, 32'h1000_0000 | sp, 0, 1));
        end
        vecs.push_back(mk(0, 32'h00, 32'h0, 1, 0, 0, 0, 32'h00, NOP, 0, 1));
        // Flush with a simultaneous push while full.
        vecs.push_back(mk(1, 32'h20, 32'hAAAA_0001, 0, 0, 1, 1, 32'h20, 32'hAAAA_0001, 0, 1));
        vecs.push_back(mk(1, 32'h24, 32'hAAAA_0002, 0, 0, 2, 1, 32'h20, 32'hAAAA_0001, 0, 0));
        vecs.push_back(mk(1, 32'h40, 32'hBBBB_0040, 0, 1, 0, 0, 32'h00, NOP,            0, 1));
        vecs.push_back(mk(0, 32'h00, 32'h0,         1, 0, 0, 0, 32'h00, NOP,            0, 1));
        // Misaligned head, held stable under backpressure, then popped.
        vecs.push_back(mk(1, 32'h06, 32'hCCCC_0006, 0, 0, 1, 1, 32'h06, 32'hCCCC_0006, 1, 1));
        vecs.push_back(mk(0, 32'h00, 32'h0,         0, 0, 1, 1, 32'h06, 32'hCCCC_0006, 1, 1));
        vecs.push_back(mk(0, 32'h00, 32'h0,         1, 0, 0, 0, 32'h00, NOP,            0, 1));

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].pc, vecs[i].instr, vecs[i].rdy, vecs[i].fl);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].vld, vecs[i].epc,
                      vecs[i].einstr, vecs[i].mis, vecs[i].irdy);
        end

        // Randomised traffic against the queue model (buffer is empty here).
        model_q.delete();
        for (int i = 0; i < 400; i++) begin
            iv  = 1'($urandom_range(0, 3) != 0);
            rdy = 1'($urandom_range(0, 2) != 0);
            fl  = 1'($urandom_range(0, 15) == 0);
            rpc = $urandom;
            rin = $urandom;
            drive(iv, rpc, rin, rdy, fl);
            model_edge(iv, rpc, rin, rdy, fl);
            step();
            check_model($sformatf("rnd%0d", i));
        end

        // Asynchronous reset between edges while full.
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step();
        drive(1'b1, 32'h100, 32'h1, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h104, 32'h2, 1'b0, 1'b0);
        step();
        check_all("prefill", 2'd2, 1'b1, 32'h100, 32'h1, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 2'd0, 1'b0, 32'h0, NOP, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_all("post_rst", 2'd0, 1'b0, 32'h0, NOP, 1'b0, 1'b1);
        drive(1'b1, 32'h200, 32'h3, 1'b0, 1'b0);
        step();
        check_all("post_rst_push", 2'd1, 1'b1, 32'h200, 32'h3, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
